// File: rtl/iod_tx_lane_pkg.sv
// iod_tx_lane_pkg: shared types and widths for the TX IOD lane controller
package iod_tx_lane_pkg;
   localparam int STATE_W = 3;
   localparam int IOD_TX_DATA_W = 8;
   localparam int IOD_OE_W = 4;
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SYNC_RST  = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_OE_ON     = 3'd4,
      ST_TRAIN     = 3'd5,
      ST_DATA      = 3'd6
   } lane_state_t;
   function automatic int max_of(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/iod_sync2.sv
// iod_sync2: two-flop synchroniser for a single asynchronous level
module iod_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   // shift the level through two flops, cleared by the async reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/iod_tx_lane_ctrl.sv
// iod_tx_lane_ctrl: bring-up sequencer and data path for one DDR x4 TX IOD lane
module iod_tx_lane_ctrl
   import iod_tx_lane_pkg::*;
#(
   parameter int                       SYNC_RST_CYCLES = 8,
   parameter int                       SETTLE_CYCLES   = 16,
   parameter int                       OE_LEAD_CYCLES  = 2,
   parameter int                       TRAIN_CYCLES    = 64,
   parameter logic [IOD_TX_DATA_W-1:0] TRAIN_PATTERN   = 8'h55,
   parameter logic [IOD_TX_DATA_W-1:0] IDLE_PATTERN    = 8'h00,
   parameter logic                     ODT_WHEN_IDLE   = 1'b0
) (
   input  logic                     FAB_CLK,
   input  logic                     ARST_N,
   input  logic                     PLL_LOCK,
   input  logic                     ENABLE,
   input  logic [IOD_TX_DATA_W-1:0] USR_DATA,
   input  logic                     USR_VALID,
   output logic                     USR_READY,
   output logic                     TX_SYNC_RST,
   output logic [IOD_TX_DATA_W-1:0] TX_DATA_0,
   output logic [IOD_OE_W-1:0]      OE_DATA_0,
   output logic                     ODT_EN_0,
   output logic                     LANE_READY,
   output logic [STATE_W-1:0]       STATE
);
   localparam int CNT_MAX = max_of(max_of(SYNC_RST_CYCLES, SETTLE_CYCLES), max_of(OE_LEAD_CYCLES, TRAIN_CYCLES));
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   lane_state_t      state, nxt;
   logic [CNT_W-1:0] cnt, lim;
   logic             lock_s, done, timed;
   iod_sync2 u_lock_sync (
      .clk  (FAB_CLK),
      .rst_n(ARST_N),
      .d    (PLL_LOCK),
      .q    (lock_s)
   );
   // next state: enable drop beats lock loss, which beats the timed sequence
   always_comb begin
      timed = state inside {ST_SYNC_RST, ST_SETTLE, ST_OE_ON, ST_TRAIN};
      lim = state == ST_SYNC_RST ? CNT_W'(SYNC_RST_CYCLES - 1)
          : state == ST_SETTLE   ? CNT_W'(SETTLE_CYCLES - 1)
          : state == ST_OE_ON    ? CNT_W'(OE_LEAD_CYCLES - 1)
          :                        CNT_W'(TRAIN_CYCLES - 1);
      done = timed && cnt == lim;
      nxt = !ENABLE                            ? ST_IDLE
          : !lock_s && state >= ST_SYNC_RST    ? ST_WAIT_LOCK
          : state == ST_IDLE                   ? ST_WAIT_LOCK
          : state == ST_WAIT_LOCK              ? (lock_s ? ST_SYNC_RST : ST_WAIT_LOCK)
          : done                               ? lane_state_t'(state + 3'd1)
          :                                      state;
   end
   // state, shared counter and lane pins all registered from the next state
   always_ff @(posedge FAB_CLK or negedge ARST_N)
      if (!ARST_N) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         TX_SYNC_RST <= 1'b1;
         TX_DATA_0   <= IDLE_PATTERN;
         OE_DATA_0   <= '0;
         ODT_EN_0    <= ODT_WHEN_IDLE;
      end else begin
         state       <= nxt;
         cnt         <= (nxt != state || !timed) ? '0 : cnt + CNT_W'(1);
         TX_SYNC_RST <= (nxt <= ST_SYNC_RST);
         OE_DATA_0   <= nxt >= ST_OE_ON ? '1 : '0;
         ODT_EN_0    <= nxt >= ST_OE_ON ? 1'b0 : ODT_WHEN_IDLE;
         TX_DATA_0   <= nxt == ST_TRAIN ? TRAIN_PATTERN
                      : (nxt == ST_DATA && state == ST_DATA && USR_VALID) ? USR_DATA
                      : IDLE_PATTERN;
      end
   assign USR_READY  = state == ST_DATA;
   assign LANE_READY = state == ST_DATA;
   assign STATE      = state;
endmodule

// File: tb/tb_iod_tx_lane_ctrl.sv
// tb_iod_tx_lane_ctrl: randomized bench against a timeline model of the lane bring-up
module tb_iod_tx_lane_ctrl;
   localparam int S = 8, SE = 16, O = 2, T = 64;
   localparam int LAST = S + SE + O + T;
   localparam logic ODT_IDLE = 1'b0;
   logic       FAB_CLK = 0, ARST_N = 0, PLL_LOCK = 0, ENABLE = 0, USR_VALID = 0;
   logic [7:0] USR_DATA = 0;
   logic       USR_READY, TX_SYNC_RST, ODT_EN_0, LANE_READY;
   logic [7:0] TX_DATA_0;
   logic [3:0] OE_DATA_0;
   logic [2:0] STATE;
   int         n_cmp = 0, n_bad = 0;
   int         mode, t;
   logic       l1, l2;
   logic [7:0] m_data;
   iod_tx_lane_ctrl dut (
      .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .PLL_LOCK(PLL_LOCK), .ENABLE(ENABLE),
      .USR_DATA(USR_DATA), .USR_VALID(USR_VALID), .USR_READY(USR_READY),
      .TX_SYNC_RST(TX_SYNC_RST), .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0),
      .ODT_EN_0(ODT_EN_0), .LANE_READY(LANE_READY), .STATE(STATE)
   );
   always #5 FAB_CLK = ~FAB_CLK;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // mode 0 = off, 1 = waiting for lock, 2 = sequencing with t cycles since lock seen
   function automatic int phase();
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      if (t < S) return 2;
      if (t < S + SE) return 3;
      if (t < S + SE + O) return 4;
      if (t < LAST) return 5;
      return 6;
   endfunction
   task automatic reset_model();
      mode = 0; t = 0; l1 = 0; l2 = 0; m_data = 8'h00;
   endtask
   task automatic compare_all();
      int p;
      p = phase();
      check("state", 32'(STATE), 32'(p));
      check("sync_rst", 32'(TX_SYNC_RST), 32'(p <= 2));
      check("oe", 32'(OE_DATA_0), p >= 4 ? 32'hF : 32'h0);
      check("odt", 32'(ODT_EN_0), p >= 4 ? 32'h0 : 32'(ODT_IDLE));
      check("usr_ready", 32'(USR_READY), 32'(p == 6));
      check("lane_ready", 32'(LANE_READY), 32'(p == 6));
      check("tx_data", 32'(TX_DATA_0), 32'(m_data));
   endtask
   task automatic model(input logic en, input logic lk, input logic v, input logic [7:0] d);
      logic ls, was, now;
      ls = l2; l2 = l1; l1 = lk;
      was = phase() == 6;
      if (!en) mode = 0;
      else if (mode == 2 && !ls) mode = 1;
      else if (mode == 0) mode = 1;
      else if (mode == 1 && ls) begin mode = 2; t = 0; end
      else if (mode == 2 && t < LAST) t++;
      now = phase() == 6;
      m_data = phase() == 5 ? 8'h55 : (was && now && v) ? d : 8'h00;
   endtask
   task automatic step(input logic en, input logic lk, input logic v, input logic [7:0] d);
      ENABLE = en; PLL_LOCK = lk; USR_VALID = v; USR_DATA = d;
      @(posedge FAB_CLK);
      model(en, lk, v, d);
      @(negedge FAB_CLK);
      compare_all();
   endtask
   initial begin
      logic lk_r;
      reset_model();
      repeat (3) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      compare_all();
      ARST_N = 1;
      for (int i = 0; i < 5; i++) step(1, 0, 1'($urandom), 8'($urandom));
      for (int i = 0; i < LAST + 10; i++) step(1, 1, 1'($urandom), 8'($urandom));
      for (int i = 1; i <= 16; i++) step(1, 1, 1, 8'(i));
      step(1, 1, 0, 8'h00);
      step(1, 1, 1, 8'hA5);
      step(1, 1, 0, 8'($urandom));
      step(1, 1, 1, 8'h3C);
      step(1, 1, 0, 8'h00);
      for (int i = 0; i < 100; i++) step(1, 1, 1'($urandom), 8'($urandom));
      step(0, 1, 1, 8'h99);
      for (int i = 0; i < 200 && phase() != 5; i++) step(1, 1, 1'($urandom), 8'($urandom));
      for (int i = 0; i < 10; i++) step(1, 1, 1'($urandom), 8'($urandom));
      for (int i = 0; i < 5; i++) step(1, 0, 1'($urandom), 8'($urandom));
      for (int i = 0; i < LAST + 10; i++) step(1, 1, 1'($urandom), 8'($urandom));
      for (int i = 0; i < 20; i++) step(1, 1, 1'($urandom), 8'($urandom));
      step(0, 1, 0, 8'h00);
      for (int i = 0; i < 200 && phase() != 3; i++) step(1, 1, 1'($urandom), 8'($urandom));
      for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h00);
      #2 ARST_N = 0;
      #1 reset_model();
      compare_all();
      repeat (2) @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      compare_all();
      ARST_N = 1;
      for (int i = 0; i < LAST + 20; i++) step(1, 1, 1'($urandom), 8'($urandom));
      lk_r = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) lk_r = ~lk_r;
         step($urandom_range(0, 199) != 0, lk_r, 1'($urandom), 8'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
